wots_pk_from_sig: RTL and testbench
===================================

Name: wots_pk_from_sig

Overview:
- WOTS verifier-side core: the counterpart of public key generation.
- Takes a 256-bit message digest and a WOTS signature already stored in a dual-port memory.
- Derives the base-w digits plus checksum digits, then completes each chain from the digit position to step WOTS_W-1 via the shared gen_chain core.
- Writes the WOTS_LEN resulting public key elements to a pk memory for L-tree compression.

Parameters:
- WOTS_W, 16, Winternitz parameter; only 16 is supported.
- WOTS_LEN, 67, total chains (WOTS_LEN1=64 message digits + WOTS_LEN2=3 checksum digits).
- KEY_LEN, 256, element width in bits.
- WOTS_LOG_W, CLOG2(WOTS_W), digit width (4).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; sampled only in IDLE
- msg  in  256  message digest; sampled at start
- pub_seed  in  KEY_LEN  public seed; sampled at start
- hash_addr  in  256  initial OTS hash address; sampled at start
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  one-cycle pulse at completion
- hash_addr_out  out  256  final address after the last chain
- sig_mem_rd_en  out  1  signature memory read enable
- sig_mem_rd_addr  out  CLOG2(WOTS_LEN)  signature element index
- sig_mem_dout  in  KEY_LEN  read data, valid one cycle after rd_en
- pk_wr_en  out  1  pk memory write strobe
- pk_wr_addr  out  CLOG2(WOTS_LEN)  pk element index
- pk_wr_data  out  KEY_LEN  pk element
- gen_chain_start  out  1  one-cycle pulse
- gen_chain_input_key  out  KEY_LEN  equals latched pub_seed
- gen_chain_input_data  out  KEY_LEN  latched signature element
- gen_chain_start_step  out  WOTS_LOG_W  digit value
- gen_chain_end_step  out  WOTS_LOG_W  constant WOTS_W-1
- gen_chain_hash_addr  out  256  address with chain field set
- gen_chain_data_out  in  KEY_LEN  chain result
- gen_chain_done  in  1  chain completion pulse
- gen_chain_hash_addr_updated  in  256  address after the chain

Behaviour:
- Reset (asynchronous, reset_n=0): FSM to IDLE; all outputs and internal registers cleared to 0. Reset mid-operation aborts immediately; no further memory writes occur.
- Digits: d_i = msg[255-4i -: 4] for i=0..63, MSB nibble first.
- Checksum: csum = sum over i of (15 - d_i), a 12-bit value (max 960). Checksum digits are d_64=csum[11:8], d_65=csum[7:4], d_66=csum[3:0].
- Address: chain field is word 5, bits [95:64]. gen_chain_hash_addr = latched hash_addr with bits [95:64] = i. All other bits pass through unchanged.
- IDLE: on start, latch msg, pub_seed and hash_addr; clear the accumulator; go to CSUM. A start pulse while busy is ignored.
- CSUM: 64 cycles, accumulating one digit per cycle; i=0 on exit. Go to RD.
- RD: sig_mem_rd_en=1, sig_mem_rd_addr=i, for one cycle. Go to LATCH.
- LATCH: capture sig_mem_dout.
  - If d_i==15 (bypass), go to WRITE with data = the signature element.
  - Otherwise go to CSTART.
- CSTART: gen_chain_start=1 for one cycle with start_step=d_i and end_step=15. gen_chain performs end-start hashes. Go to CWAIT.
- CWAIT: hold all gen_chain inputs stable. On gen_chain_done, capture data_out and hash_addr_updated; go to WRITE.
- WRITE: pk_wr_en=1, pk_wr_addr=i, for one cycle.
  - If i==WOTS_LEN-1, go to FIN; otherwise i++ and go to RD.
- FIN: done=1 for one cycle; busy=0; hash_addr_out registered.
  - hash_addr_out = last captured hash_addr_updated.
  - If the final chain was bypassed, hash_addr_out = gen_chain_hash_addr of chain 66.
  - Return to IDLE.
- Exactly WOTS_LEN writes occur per run, at strictly ascending addresses 0..66. pk_wr_en and sig_mem_rd_en are never high in the same cycle.
- Latency: start to done = 1 + 64 + sum over chains of (3 if bypassed, else 4 + gen_chain latency) + 1 cycles.

Test Plan:
- msg=all 1s -> chains 0..63 bypass; pk[i]=sig[i] for i<64. csum=0, so chains 64..66 start at step 0 with 15 hashes each. Exactly 67 writes; done one pulse.
- msg=all 0s -> csum=960=0x3C0, giving digits 3,C,0. start_step seen as 0 (x64), 3, 12, 0. pk matches the C reference xmss-core wots_pk_from_sig output.
- Random msg with a stubbed gen_chain of fixed 20-cycle latency -> start-to-done cycle count matches the latency formula exactly; gen_chain_hash_addr[95:64] equals i on every start.
- Round trip: gen_pk keys -> sign -> this block on the signature -> pk memory equals the gen_pk output for all 67 entries.
- start re-pulsed during CWAIT -> ignored; outputs unchanged.
- reset_n low during chain 30 CWAIT -> busy, done and all strobes drop immediately. A new start after release completes correctly.

Source files
------------

// File: rtl/wots_pk_from_sig.sv
// WOTS public-key-from-signature core: derives base-16 digits and checksum from a digest, then
// completes every signature chain to step WOTS_W-1 through an external gen_chain engine.
module wots_pk_from_sig #(
  parameter int unsigned WOTS_W     = 16,
  parameter int unsigned WOTS_LEN   = 67,
  parameter int unsigned KEY_LEN    = 256,
  parameter int unsigned WOTS_LOG_W = $clog2(WOTS_W),
  parameter int unsigned LEN_W      = $clog2(WOTS_LEN)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [255:0]          msg,
  input  logic [KEY_LEN-1:0]    pub_seed,
  input  logic [255:0]          hash_addr,
  output logic                  busy,
  output logic                  done,
  output logic [255:0]          hash_addr_out,
  output logic                  sig_mem_rd_en,
  output logic [LEN_W-1:0]      sig_mem_rd_addr,
  input  logic [KEY_LEN-1:0]    sig_mem_dout,
  output logic                  pk_wr_en,
  output logic [LEN_W-1:0]      pk_wr_addr,
  output logic [KEY_LEN-1:0]    pk_wr_data,
  output logic                  gen_chain_start,
  output logic [KEY_LEN-1:0]    gen_chain_input_key,
  output logic [KEY_LEN-1:0]    gen_chain_input_data,
  output logic [WOTS_LOG_W-1:0] gen_chain_start_step,
  output logic [WOTS_LOG_W-1:0] gen_chain_end_step,
  output logic [255:0]          gen_chain_hash_addr,
  input  logic [KEY_LEN-1:0]    gen_chain_data_out,
  input  logic                  gen_chain_done,
  input  logic [255:0]          gen_chain_hash_addr_updated
);

  localparam int unsigned WOTS_LEN1 = 64;
  localparam logic [LEN_W-1:0] MsgLastIdx = LEN_W'(WOTS_LEN1 - 1);
  localparam logic [LEN_W-1:0] LastIdx    = LEN_W'(WOTS_LEN - 1);
  localparam logic [LEN_W-1:0] IdxOne     = LEN_W'(1);
  localparam logic [WOTS_LOG_W-1:0] MaxStep = WOTS_LOG_W'(WOTS_W - 1);

  typedef enum logic [2:0] {
    StIdle, StCsum, StRd, StLatch, StCstart, StCwait, StWrite, StFin
  } state_e;

  state_e         state_q;
  logic [255:0]   msg_q;
  logic [255:0]   hash_addr_q;
  logic [255:0]   last_addr_q;
  logic [11:0]    csum_q;
  logic [LEN_W-1:0] idx_q;
  logic [255:0]   msg_shift;
  logic [3:0]     digit;

  assign gen_chain_end_step = MaxStep;

  // idx_q doubles as the digit counter during the checksum pass.
  always_comb begin
    msg_shift = msg_q << {idx_q[5:0], 2'b00};
    digit     = msg_shift[255:252];
    if (idx_q > MsgLastIdx) begin
      unique case (idx_q[1:0])
        2'd0:    digit = csum_q[11:8];
        2'd1:    digit = csum_q[7:4];
        default: digit = csum_q[3:0];
      endcase
    end
  end

  function automatic logic [255:0] chain_addr(input logic [255:0] base,
                                              input logic [LEN_W-1:0] idx);
    return {base[255:96], {(32 - LEN_W){1'b0}}, idx, base[63:0]};
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q              <= StIdle;
      msg_q                <= '0;
      hash_addr_q          <= '0;
      last_addr_q          <= '0;
      csum_q               <= '0;
      idx_q                <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      hash_addr_out        <= '0;
      sig_mem_rd_en        <= 1'b0;
      sig_mem_rd_addr      <= '0;
      pk_wr_en             <= 1'b0;
      pk_wr_addr           <= '0;
      pk_wr_data           <= '0;
      gen_chain_start      <= 1'b0;
      gen_chain_input_key  <= '0;
      gen_chain_input_data <= '0;
      gen_chain_start_step <= '0;
      gen_chain_hash_addr  <= '0;
    end else begin
      done            <= 1'b0;
      sig_mem_rd_en   <= 1'b0;
      pk_wr_en        <= 1'b0;
      gen_chain_start <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            msg_q               <= msg;
            hash_addr_q         <= hash_addr;
            gen_chain_input_key <= pub_seed;
            csum_q              <= '0;
            idx_q               <= '0;
            busy                <= 1'b1;
            state_q             <= StCsum;
          end
        end
        StCsum: begin
          csum_q <= csum_q + {8'b0, ~digit};
          if (idx_q == MsgLastIdx) begin
            idx_q               <= '0;
            sig_mem_rd_en       <= 1'b1;
            sig_mem_rd_addr     <= '0;
            gen_chain_hash_addr <= chain_addr(hash_addr_q, '0);
            state_q             <= StRd;
          end else begin
            idx_q <= idx_q + IdxOne;
          end
        end
        StRd: state_q <= StLatch;
        StLatch: begin
          gen_chain_input_data <= sig_mem_dout;
          gen_chain_start_step <= digit;
          if (digit == MaxStep) begin
            // Chain already at its end: the signature element is the pk element.
            pk_wr_en    <= 1'b1;
            pk_wr_addr  <= idx_q;
            pk_wr_data  <= sig_mem_dout;
            last_addr_q <= gen_chain_hash_addr;
            state_q     <= StWrite;
          end else begin
            gen_chain_start <= 1'b1;
            state_q         <= StCstart;
          end
        end
        StCstart: state_q <= StCwait;
        StCwait: begin
          if (gen_chain_done) begin
            pk_wr_en    <= 1'b1;
            pk_wr_addr  <= idx_q;
            pk_wr_data  <= gen_chain_data_out;
            last_addr_q <= gen_chain_hash_addr_updated;
            state_q     <= StWrite;
          end
        end
        StWrite: begin
          if (idx_q == LastIdx) begin
            done          <= 1'b1;
            busy          <= 1'b0;
            hash_addr_out <= last_addr_q;
            state_q       <= StFin;
          end else begin
            idx_q               <= idx_q + IdxOne;
            sig_mem_rd_en       <= 1'b1;
            sig_mem_rd_addr     <= idx_q + IdxOne;
            gen_chain_hash_addr <= chain_addr(hash_addr_q, idx_q + IdxOne);
            state_q             <= StRd;
          end
        end
        StFin: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_wots_pk_from_sig.sv
// Directed bench for wots_pk_from_sig: memories and a fixed-latency additive gen_chain stub,
// with expected pk values, digits, addresses and cycle counts derived in the bench.
module tb_wots_pk_from_sig;

  localparam int WOTS_LEN = 67;
  localparam int CHAIN_LAT = 20;
  localparam int LOG_N = 2048;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] msg = '0;
  logic [255:0] pub_seed = '0;
  logic [255:0] hash_addr = '0;
  logic         busy, done;
  logic [255:0] hash_addr_out;
  logic         sig_mem_rd_en;
  logic [6:0]   sig_mem_rd_addr;
  logic [255:0] sig_mem_dout;
  logic         pk_wr_en;
  logic [6:0]   pk_wr_addr;
  logic [255:0] pk_wr_data;
  logic         gen_chain_start;
  logic [255:0] gen_chain_input_key, gen_chain_input_data;
  logic [3:0]   gen_chain_start_step, gen_chain_end_step;
  logic [255:0] gen_chain_hash_addr;
  logic [255:0] gen_chain_data_out;
  logic         gen_chain_done;
  logic [255:0] gen_chain_hash_addr_updated;

  wots_pk_from_sig dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .start                       (start),
    .msg                         (msg),
    .pub_seed                    (pub_seed),
    .hash_addr                   (hash_addr),
    .busy                        (busy),
    .done                        (done),
    .hash_addr_out               (hash_addr_out),
    .sig_mem_rd_en               (sig_mem_rd_en),
    .sig_mem_rd_addr             (sig_mem_rd_addr),
    .sig_mem_dout                (sig_mem_dout),
    .pk_wr_en                    (pk_wr_en),
    .pk_wr_addr                  (pk_wr_addr),
    .pk_wr_data                  (pk_wr_data),
    .gen_chain_start             (gen_chain_start),
    .gen_chain_input_key         (gen_chain_input_key),
    .gen_chain_input_data        (gen_chain_input_data),
    .gen_chain_start_step        (gen_chain_start_step),
    .gen_chain_end_step          (gen_chain_end_step),
    .gen_chain_hash_addr         (gen_chain_hash_addr),
    .gen_chain_data_out          (gen_chain_data_out),
    .gen_chain_done              (gen_chain_done),
    .gen_chain_hash_addr_updated (gen_chain_hash_addr_updated)
  );

  always #5 clk = ~clk;

  localparam logic [255:0] Seed = 256'h0000_0000_0000_0000_0000_0000_0000_0001_0203_0405_0607_0809_0a0b_0c0d_0e0f_1011;
  localparam logic [255:0] BaseAddr = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
                                       32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};

  // Signature memory: registered read.
  logic [255:0] sig_mem [WOTS_LEN];
  always @(posedge clk) if (sig_mem_rd_en) sig_mem_dout <= sig_mem[sig_mem_rd_addr];

  // Chain stub: each hash step adds the key; address advances by the number of steps.
  int           sc;
  logic [255:0] sd, sa;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sc <= 0; sd <= '0; sa <= '0;
    end else if (gen_chain_start) begin
      sc <= CHAIN_LAT;
      sd <= gen_chain_input_data + gen_chain_input_key * 256'(gen_chain_end_step - gen_chain_start_step);
      sa <= gen_chain_hash_addr + 256'(gen_chain_end_step - gen_chain_start_step);
    end else if (sc != 0) begin
      sc <= sc - 1;
    end
  end
  assign gen_chain_done = (sc == 1);
  assign gen_chain_data_out = sd;
  assign gen_chain_hash_addr_updated = sa;

  // Event logs sampled on the falling edge.
  int           wr_cnt = 0, st_cnt = 0, done_cnt = 0, overlap = 0;
  logic [6:0]   wr_addr_log [LOG_N];
  logic [255:0] wr_data_log [LOG_N];
  logic [3:0]   st_step_log [LOG_N];
  logic [255:0] st_addr_log [LOG_N];
  logic [255:0] st_data_log [LOG_N];
  always @(negedge clk) begin
    if (pk_wr_en) begin
      if (wr_cnt < LOG_N) begin
        wr_addr_log[wr_cnt] = pk_wr_addr;
        wr_data_log[wr_cnt] = pk_wr_data;
      end
      wr_cnt++;
    end
    if (gen_chain_start) begin
      if (st_cnt < LOG_N) begin
        st_step_log[st_cnt] = gen_chain_start_step;
        st_addr_log[st_cnt] = gen_chain_hash_addr;
        st_data_log[st_cnt] = gen_chain_input_data;
      end
      st_cnt++;
    end
    if (done) done_cnt++;
    if (pk_wr_en && sig_mem_rd_en) overlap++;
  end

  int total = 0, bad = 0;
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] model_digit(input logic [255:0] m, input int i);
    logic [11:0] cs;
    logic [3:0]  nib;
    cs = '0;
    if (i < 64) return m[255-4*i -: 4];
    for (int k = 0; k < 64; k++) begin
      nib = m[255-4*k -: 4];
      cs = cs + {8'b0, 4'd15 - nib};
    end
    if (i == 64) return cs[11:8];
    if (i == 65) return cs[7:4];
    return cs[3:0];
  endfunction

  function automatic logic [255:0] model_addr(input int i);
    logic [255:0] a;
    a = BaseAddr;
    a[95:64] = 32'(i);
    return a;
  endfunction

  function automatic logic [255:0] secret(input int i);
    return {8{32'h5a000000 + 32'(i) * 32'h00010001}};
  endfunction

  // Signature of m under the stub's chain: sk + d*seed; the pk is then sk + 15*seed.
  task automatic load_sig(input logic [255:0] m);
    for (int i = 0; i < WOTS_LEN; i++)
      sig_mem[i] = secret(i) + Seed * 256'(model_digit(m, i));
  endtask

  int last_wb, last_sb;

  task automatic do_run(input string tag, input logic [255:0] m, input int exp_lat,
                        input bit repulse);
    int lat, wb, sb, db, ob, nw, ns, j, bad_a, bad_d, n_exp, bad_s;
    bit got, pend, did;
    logic [3:0] d;
    logic [255:0] exp_out;
    load_sig(m);
    wb = wr_cnt; sb = st_cnt; db = done_cnt; ob = overlap;
    last_wb = wb; last_sb = sb;
    @(negedge clk);
    msg = m; pub_seed = Seed; hash_addr = BaseAddr; start = 1'b1;
    lat = 1; got = 0; pend = 0; did = 0;
    while (!got && lat < 5000) begin
      @(negedge clk);
      lat++;
      start = 1'b0; msg = m; pub_seed = Seed; hash_addr = BaseAddr;
      if (pend) begin
        start = 1'b1; msg = ~m; pub_seed = ~Seed; hash_addr = ~BaseAddr; pend = 0;
      end
      if (repulse && !did && gen_chain_start) begin pend = 1; did = 1; end
      if (done) got = 1;
    end
    chk({tag, " done_seen"}, 256'(got), 256'd1);
    chk({tag, " latency"}, 256'(lat), 256'(exp_lat));
    d = model_digit(m, 66);
    exp_out = (d == 4'hF) ? model_addr(66) : model_addr(66) + 256'(4'd15 - d);
    chk({tag, " hash_addr_out"}, hash_addr_out, exp_out);
    @(negedge clk);
    @(negedge clk);
    chk({tag, " done_pulses"}, 256'(done_cnt - db), 256'd1);
    chk({tag, " idle_after"}, {busy, done}, 2'b00);
    nw = wr_cnt - wb;
    chk({tag, " writes"}, 256'(nw), 256'(WOTS_LEN));
    bad_a = 0; bad_d = 0;
    for (int k = 0; k < nw && k < WOTS_LEN; k++) begin
      if (wr_addr_log[wb+k] != 7'(k)) bad_a++;
      if (wr_data_log[wb+k] != secret(k) + Seed * 256'd15) bad_d++;
    end
    chk({tag, " wr_order"}, 256'(bad_a), 256'd0);
    chk({tag, " pk_data"}, 256'(bad_d), 256'd0);
    ns = st_cnt - sb;
    n_exp = 0;
    for (int i = 0; i < WOTS_LEN; i++) if (model_digit(m, i) != 4'hF) n_exp++;
    chk({tag, " chain_starts"}, 256'(ns), 256'(n_exp));
    j = 0; bad_s = 0;
    for (int i = 0; i < WOTS_LEN; i++) begin
      d = model_digit(m, i);
      if (d != 4'hF) begin
        if (j < ns) begin
          if (st_step_log[sb+j] != d) bad_s++;
          if (st_addr_log[sb+j] != model_addr(i)) bad_s++;
          if (st_data_log[sb+j] != sig_mem[i]) bad_s++;
        end
        j++;
      end
    end
    chk({tag, " chain_inputs"}, 256'(bad_s), 256'd0);
    chk({tag, " rd_wr_overlap"}, 256'(overlap - ob), 256'd0);
  endtask

  localparam logic [255:0] MsgOnes  = ~256'd0;
  localparam logic [255:0] MsgZeros = 256'd0;
  localparam logic [255:0] MsgMix   = {4{64'h0123456789ABCDEF}};
  localparam logic [255:0] MsgRt    = ~256'd15;

  initial begin
    int guard, wb;
    #23;
    chk("reset busy", 256'(busy), 256'd0);
    chk("reset strobes", {done, pk_wr_en, sig_mem_rd_en, gen_chain_start}, 4'b0000);
    chk("reset hash_addr_out", hash_addr_out, 256'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // csum=0 -> digits 0,0,0; 64 bypasses plus three 15-step chains.
    do_run("ones", MsgOnes, 330, 1'b0);
    chk("ones pk0_bypass", wr_data_log[last_wb], sig_mem[0]);
    chk("ones pk64_chain", wr_data_log[last_wb+64], sig_mem[64] + Seed * 256'd15);

    // csum=960=0x3C0 -> checksum digits 3, C, 0.
    do_run("zeros", MsgZeros, 1674, 1'b0);
    chk("zeros step0", 256'(st_step_log[last_sb]), 256'd0);
    chk("zeros step64", 256'(st_step_log[last_sb+64]), 256'd3);
    chk("zeros step65", 256'(st_step_log[last_sb+65]), 256'd12);
    chk("zeros step66", 256'(st_step_log[last_sb+66]), 256'd0);

    // csum=480=0x1E0, four bypasses; a second start is pulsed during the first chain wait.
    do_run("mix_repulse", MsgMix, 1590, 1'b1);

    // csum=15 -> final checksum digit is F, so the last chain is bypassed.
    do_run("roundtrip", MsgRt, 330, 1'b0);

    // Abort during chain 30's wait.
    load_sig(MsgZeros);
    wb = wr_cnt;
    @(negedge clk);
    msg = MsgZeros; pub_seed = Seed; hash_addr = BaseAddr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!(gen_chain_start && gen_chain_hash_addr[95:64] == 32'd30) && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    chk("abort reached_chain30", 256'(guard < 3000), 256'd1);
    repeat (5) @(negedge clk);
    chk("abort writes_before", 256'(wr_cnt - wb), 256'd30);
    #2 reset_n = 1'b0;
    #1;
    chk("abort busy", 256'(busy), 256'd0);
    chk("abort strobes", {done, pk_wr_en, sig_mem_rd_en, gen_chain_start}, 4'b0000);
    wb = wr_cnt;
    repeat (3) @(negedge clk);
    chk("abort no_writes", 256'(wr_cnt - wb), 256'd0);
    reset_n = 1'b1;
    @(negedge clk);
    do_run("after_abort", MsgMix, 1590, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
